// File: rtl/wr_matcher_if.sv
// Worker-result input channel and match-token output channel of wr_matcher.
// master: the side driving results in and accepting tokens out.
// slave: the matcher itself.
interface wr_matcher_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32
);
  localparam int WR_WIDTH = 2 + ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH;
  localparam int MT_WIDTH = ADDR_WIDTH + COLOR_WIDTH + 2 * DATA_WIDTH;

  logic                RECEIVE_WR_VALID;
  logic [WR_WIDTH-1:0] RECEIVE_WR_DATA;
  logic                RECEIVE_WR_READY;
  logic                SEND_MT_VALID;
  logic [MT_WIDTH-1:0] SEND_MT_DATA;
  logic                SEND_MT_READY;

  modport master (
    output RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_MT_READY,
    input  RECEIVE_WR_READY, SEND_MT_VALID, SEND_MT_DATA
  );

  modport slave (
    input  RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_MT_READY,
    output RECEIVE_WR_READY, SEND_MT_VALID, SEND_MT_DATA
  );
endinterface

// File: rtl/wr_matcher.sv
// Operand matcher: pairs LEFT/RIGHT worker results sharing {addr, color}
// in a small associative waiting table; ONE results bypass the table.
// Every output is registered; one result is processed per
// receive -> lookup (-> send) pass of the FSM.
module wr_matcher #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int ENTRIES     = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  wr_matcher_if.slave                  bus,
  output logic                         ERR_FULL,
  output logic                         ERR_DUP,
  output logic [$clog2(ENTRIES+1)-1:0] OCCUPANCY
);
  localparam int WR_WIDTH = 2 + ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH;
  localparam int MT_WIDTH = ADDR_WIDTH + COLOR_WIDTH + 2 * DATA_WIDTH;
  localparam int OCC_W    = $clog2(ENTRIES + 1);
  localparam int IDX_W    = $clog2(ENTRIES);

  localparam logic [1:0] OPT_ONE   = 2'b00;
  localparam logic [1:0] OPT_LEFT  = 2'b01;
  localparam logic [1:0] OPT_RIGHT = 2'b10;

  typedef enum logic [1:0] {S_RECEIVE, S_LOOKUP, S_SEND} state_t;

  state_t                                  state;
  logic [WR_WIDTH-1:0]                     current_wr;

  // Waiting table: side 0 = left operand, 1 = right operand
  logic [ENTRIES-1:0]                      tbl_vld;
  logic [ENTRIES-1:0]                      tbl_side;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0]      tbl_addr;
  logic [ENTRIES-1:0][COLOR_WIDTH-1:0]     tbl_color;
  logic [ENTRIES-1:0][DATA_WIDTH-1:0]      tbl_data;

  logic [1:0]                              cur_opt;
  logic [ADDR_WIDTH-1:0]                   cur_addr;
  logic [COLOR_WIDTH-1:0]                  cur_color;
  logic [DATA_WIDTH-1:0]                   cur_data;
  logic                                    cur_side;

  logic [ENTRIES-1:0]                      opp_hit, same_hit;
  logic                                    opp_any, same_any, free_any;
  logic [IDX_W-1:0]                        opp_idx, free_idx;

  assign cur_opt   = current_wr[WR_WIDTH-1 -: 2];
  assign cur_addr  = current_wr[WR_WIDTH-3 -: ADDR_WIDTH];
  assign cur_color = current_wr[DATA_WIDTH+COLOR_WIDTH-1 -: COLOR_WIDTH];
  assign cur_data  = current_wr[DATA_WIDTH-1:0];
  // RIGHT is the only waiting option with bit 1 set
  assign cur_side  = cur_opt[1];

  // Per-entry key compare, split by which side the waiting operand is on
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    logic key_hit;
    assign key_hit     = tbl_vld[g] && (tbl_addr[g] == cur_addr) && (tbl_color[g] == cur_color);
    assign opp_hit[g]  = key_hit && (tbl_side[g] != cur_side);
    assign same_hit[g] = key_hit && (tbl_side[g] == cur_side);
  end

  assign opp_any  = |opp_hit;
  assign same_any = |same_hit;
  assign free_any = ~&tbl_vld;

  // Lowest-index priority select for the hit entry and the free slot
  always_comb begin
    opp_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (opp_hit[i]) opp_idx = IDX_W'(i);
      if (!tbl_vld[i]) free_idx = IDX_W'(i);
    end
  end

  // Control FSM with registered handshake outputs, table and flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state                <= S_RECEIVE;
      current_wr           <= '0;
      bus.RECEIVE_WR_READY <= 1'b0;
      bus.SEND_MT_VALID    <= 1'b0;
      bus.SEND_MT_DATA     <= '0;
      ERR_FULL             <= 1'b0;
      ERR_DUP              <= 1'b0;
      OCCUPANCY            <= '0;
      tbl_vld              <= '0;
      tbl_side             <= '0;
      tbl_addr             <= '0;
      tbl_color            <= '0;
      tbl_data             <= '0;
    end else begin
      case (state)
        S_RECEIVE: begin
          if (!bus.RECEIVE_WR_READY) begin
            bus.RECEIVE_WR_READY <= 1'b1;
          end else if (bus.RECEIVE_WR_VALID) begin
            current_wr           <= bus.RECEIVE_WR_DATA;
            bus.RECEIVE_WR_READY <= 1'b0;
            state                <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          state <= S_RECEIVE;
          if (cur_opt == OPT_ONE) begin
            bus.SEND_MT_DATA  <= {cur_addr, cur_color, cur_data, {DATA_WIDTH{1'b0}}};
            bus.SEND_MT_VALID <= 1'b1;
            state             <= S_SEND;
          end else if (cur_opt == OPT_LEFT || cur_opt == OPT_RIGHT) begin
            if (opp_any) begin
              bus.SEND_MT_DATA  <= cur_side ? {cur_addr, cur_color, tbl_data[opp_idx], cur_data}
                                            : {cur_addr, cur_color, cur_data, tbl_data[opp_idx]};
              bus.SEND_MT_VALID <= 1'b1;
              tbl_vld[opp_idx]  <= 1'b0;
              OCCUPANCY         <= OCCUPANCY - OCC_W'(1);
              state             <= S_SEND;
            end else if (same_any) begin
              ERR_DUP <= 1'b1;
            end else if (free_any) begin
              tbl_vld[free_idx]   <= 1'b1;
              tbl_side[free_idx]  <= cur_side;
              tbl_addr[free_idx]  <= cur_addr;
              tbl_color[free_idx] <= cur_color;
              tbl_data[free_idx]  <= cur_data;
              OCCUPANCY           <= OCCUPANCY + OCC_W'(1);
            end else begin
              ERR_FULL <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (bus.SEND_MT_VALID && bus.SEND_MT_READY) begin
            bus.SEND_MT_VALID <= 1'b0;
            state             <= S_RECEIVE;
          end
        end
        default: state <= S_RECEIVE;
      endcase
    end
  end
endmodule

// File: tb/tb_wr_matcher.sv
// Bench for wr_matcher: directed vector table, hand-written multi-cycle
// sequences (backpressure, full table, reset in S_SEND) and a random run
// against a key-indexed model of the waiting operands.
module tb_wr_matcher;
  localparam int AW  = 16;
  localparam int CW  = 16;
  localparam int DW  = 32;
  localparam int EN  = 8;
  localparam int MTW = AW + CW + 2 * DW;
  localparam int OW  = $clog2(EN + 1);

  localparam logic [1:0] ONE = 2'b00, LEFT = 2'b01, RIGHT = 2'b10, DISC = 2'b11;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          ERR_FULL, ERR_DUP;
  logic [OW-1:0] OCCUPANCY;

  wr_matcher_if #(.ADDR_WIDTH(AW), .COLOR_WIDTH(CW), .DATA_WIDTH(DW)) bus ();

  wr_matcher #(.ADDR_WIDTH(AW), .COLOR_WIDTH(CW), .DATA_WIDTH(DW), .ENTRIES(EN)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .ERR_FULL  (ERR_FULL),
    .ERR_DUP   (ERR_DUP),
    .OCCUPANCY (OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]     opt;
    logic [AW-1:0]  addr;
    logic [CW-1:0]  color;
    logic [DW-1:0]  data;
    bit             tok;
    logic [MTW-1:0] mt;
    int             occ;
    bit             efull;
    bit             edup;
  } vec_t;

  typedef struct {
    bit            side;
    logic [DW-1:0] data;
  } wait_t;

  // Push one result through the handshake and sample the lookup outcome.
  // With drain set, any token is accepted after a random stall.
  task automatic do_op(input logic [1:0] opt, input logic [AW-1:0] addr,
                       input logic [CW-1:0] color, input logic [DW-1:0] data,
                       input bit drain, output bit tok, output logic [MTW-1:0] mt);
    int t = 0;
    int d;
    @(negedge CLK);
    while (!bus.RECEIVE_WR_READY && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("recv_ready", bus.RECEIVE_WR_READY, 1);
    bus.RECEIVE_WR_VALID = 1'b1;
    bus.RECEIVE_WR_DATA  = {opt, addr, color, data};
    @(posedge CLK);
    #1 bus.RECEIVE_WR_VALID = 1'b0;
    @(posedge CLK);
    #1;
    tok = bus.SEND_MT_VALID;
    mt  = bus.SEND_MT_DATA;
    if (tok && drain) begin
      d = $urandom_range(0, 2);
      if (d > 0) begin
        repeat (d) @(posedge CLK);
        #1 chk("mt_hold", {bus.SEND_MT_VALID, bus.SEND_MT_DATA}, {1'b1, mt});
      end
      bus.SEND_MT_READY = 1'b1;
      @(posedge CLK);
      #1 bus.SEND_MT_READY = 1'b0;
      chk("mt_drop", bus.SEND_MT_VALID, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  vec_t            vt[14];
  bit              tok;
  logic [MTW-1:0]  mt;
  wait_t           mdl[bit [31:0]];
  bit              mfull, mdup;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.RECEIVE_WR_VALID = 1'b0;
    bus.RECEIVE_WR_DATA  = '0;
    bus.SEND_MT_READY    = 1'b0;

    // Reset state while held
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", bus.RECEIVE_WR_READY, 0);
    chk("rst_valid", bus.SEND_MT_VALID, 0);
    chk("rst_data", bus.SEND_MT_DATA, 0);
    chk("rst_occ", OCCUPANCY, 0);
    chk("rst_errs", {ERR_FULL, ERR_DUP}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("ready_after_rst", bus.RECEIVE_WR_READY, 1);

    // Directed vectors, applied in order from a clean table
    vt[0]  = '{LEFT,  16'h10, 16'h3, 32'd5, 0, '0, 1, 0, 0};
    vt[1]  = '{RIGHT, 16'h10, 16'h3, 32'd7, 1, {16'h10, 16'h3, 32'd5, 32'd7}, 0, 0, 0};
    vt[2]  = '{RIGHT, 16'h10, 16'h3, 32'd7, 0, '0, 1, 0, 0};
    vt[3]  = '{LEFT,  16'h10, 16'h3, 32'd5, 1, {16'h10, 16'h3, 32'd5, 32'd7}, 0, 0, 0};
    vt[4]  = '{LEFT,  16'h10, 16'h1, 32'd1, 0, '0, 1, 0, 0};
    vt[5]  = '{RIGHT, 16'h10, 16'h2, 32'd2, 0, '0, 2, 0, 0};
    vt[6]  = '{RIGHT, 16'h10, 16'h1, 32'd9, 1, {16'h10, 16'h1, 32'd1, 32'd9}, 1, 0, 0};
    vt[7]  = '{LEFT,  16'h10, 16'h2, 32'd4, 1, {16'h10, 16'h2, 32'd4, 32'd2}, 0, 0, 0};
    vt[8]  = '{LEFT,  16'h20, 16'h0, 32'd1, 0, '0, 1, 0, 0};
    vt[9]  = '{LEFT,  16'h20, 16'h0, 32'd2, 0, '0, 1, 0, 1};
    vt[10] = '{RIGHT, 16'h20, 16'h0, 32'd3, 1, {16'h20, 16'h0, 32'd1, 32'd3}, 0, 0, 1};
    vt[11] = '{ONE,   16'h31, 16'h9, 32'h12345678, 1, {16'h31, 16'h9, 32'h12345678, 32'h0}, 0, 0, 1};
    vt[12] = '{DISC,  16'h20, 16'h0, 32'd3, 0, '0, 0, 0, 1};
    vt[13] = '{DISC,  16'h44, 16'h4, 32'd8, 0, '0, 0, 0, 1};
    for (int i = 0; i < 14; i++) begin
      do_op(vt[i].opt, vt[i].addr, vt[i].color, vt[i].data, 1, tok, mt);
      chk($sformatf("vec%0d_tok", i), tok, vt[i].tok);
      if (vt[i].tok) chk($sformatf("vec%0d_mt", i), mt, vt[i].mt);
      chk($sformatf("vec%0d_occ", i), OCCUPANCY, vt[i].occ);
      chk($sformatf("vec%0d_flags", i), {ERR_FULL, ERR_DUP}, {vt[i].efull, vt[i].edup});
    end

    // ONE under backpressure: token and data hold, input side stays closed
    do_op(ONE, 16'h30, 16'h7, 32'hDEADBEEF, 0, tok, mt);
    chk("bp_tok", tok, 1);
    chk("bp_mt", mt, {16'h30, 16'h7, 32'hDEADBEEF, 32'h0});
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      chk("bp_hold", {bus.SEND_MT_VALID, bus.SEND_MT_DATA}, {1'b1, 16'h30, 16'h7, 32'hDEADBEEF, 32'h0});
      chk("bp_rdy_low", bus.RECEIVE_WR_READY, 0);
    end
    bus.SEND_MT_READY = 1'b1;
    @(posedge CLK);
    #1 bus.SEND_MT_READY = 1'b0;
    chk("bp_valid_fall", bus.SEND_MT_VALID, 0);
    chk("bp_rdy_still_low", bus.RECEIVE_WR_READY, 0);
    @(posedge CLK);
    #1 chk("bp_rdy_rise", bus.RECEIVE_WR_READY, 1);

    // Full table
    do_reset();
    for (int i = 0; i < EN; i++) begin
      do_op(LEFT, 16'h100 + 16'(i), 16'h0, 32'(i + 100), 1, tok, mt);
      chk("fill_tok", tok, 0);
      chk("fill_occ", OCCUPANCY, i + 1);
    end
    chk("fill_flags", {ERR_FULL, ERR_DUP}, 2'b00);
    do_op(LEFT, 16'h200, 16'h0, 32'd9, 1, tok, mt);
    chk("full_tok", tok, 0);
    chk("full_flag", ERR_FULL, 1);
    chk("full_occ", OCCUPANCY, EN);
    do_op(RIGHT, 16'h100, 16'h0, 32'h55, 1, tok, mt);
    chk("full_match_tok", tok, 1);
    chk("full_match_mt", mt, {16'h100, 16'h0, 32'd100, 32'h55});
    chk("full_match_occ", OCCUPANCY, EN - 1);
    chk("full_sticky", ERR_FULL, 1);

    // Reset asserted while a token waits in S_SEND
    do_op(ONE, 16'h77, 16'h1, 32'hCAFE, 0, tok, mt);
    chk("rs_tok", tok, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rs_valid", bus.SEND_MT_VALID, 0);
    chk("rs_data", bus.SEND_MT_DATA, 0);
    chk("rs_occ", OCCUPANCY, 0);
    chk("rs_errs", {ERR_FULL, ERR_DUP}, 0);
    chk("rs_ready", bus.RECEIVE_WR_READY, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1 chk("rs_ready_rel", bus.RECEIVE_WR_READY, 0);
    @(posedge CLK);
    #1 chk("rs_ready_rise", bus.RECEIVE_WR_READY, 1);
    chk("rs_valid_after", bus.SEND_MT_VALID, 0);

    // Random traffic against a map of waiting operands keyed by {addr, color}
    do_reset();
    mfull = 0;
    mdup  = 0;
    for (int n = 0; n < 300; n++) begin
      logic [1:0]     o;
      logic [AW-1:0]  a;
      logic [CW-1:0]  c;
      logic [DW-1:0]  dd;
      bit             etok;
      logic [MTW-1:0] emt;
      bit [31:0]      key;
      bit             s;
      o    = 2'($urandom_range(0, 3));
      a    = 16'($urandom_range(0, 4));
      c    = 16'($urandom_range(0, 2));
      dd   = $urandom;
      key  = {a, c};
      etok = 0;
      emt  = '0;
      if (o == ONE) begin
        etok = 1;
        emt  = {a, c, dd, 32'h0};
      end else if (o != DISC) begin
        s = (o == RIGHT);
        if (mdl.exists(key)) begin
          if (mdl[key].side != s) begin
            etok = 1;
            emt  = s ? {a, c, mdl[key].data, dd} : {a, c, dd, mdl[key].data};
            mdl.delete(key);
          end else begin
            mdup = 1;
          end
        end else if (mdl.num() < EN) begin
          mdl[key] = '{s, dd};
        end else begin
          mfull = 1;
        end
      end
      do_op(o, a, c, dd, 1, tok, mt);
      chk("rnd_tok", tok, etok);
      if (etok) chk("rnd_mt", mt, emt);
      chk("rnd_occ", OCCUPANCY, mdl.num());
      chk("rnd_flags", {ERR_FULL, ERR_DUP}, {mfull, mdup});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wr_matcher.md
# wr_matcher

Operand-matching stage on the worker-result side of the dataflow core. It accepts worker results over a valid/ready handshake and pairs left and right operands that share the same destination address and color in a small associative waiting table. Single-operand results bypass the table. Each completed pair, or single operand, is emitted as one match token toward instruction fetch/packet build.

## Interface

Parameters:
- ADDR_WIDTH, 16: instruction destination address width.
- COLOR_WIDTH, 16: color (context tag) width.
- DATA_WIDTH, 32: operand width.
- ENTRIES, 8: waiting-table depth, at least 2.
- Derived WR_WIDTH = 2+ADDR_WIDTH+COLOR_WIDTH+DATA_WIDTH. Worker result is {option[1:0], addr, color, data}, MSB first.
- Derived MT_WIDTH = ADDR_WIDTH+COLOR_WIDTH+2*DATA_WIDTH. Match token is {addr, color, data_left, data_right}.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- RECEIVE_WR_VALID  in  1  worker result valid.
- RECEIVE_WR_DATA  in  WR_WIDTH  worker result.
- RECEIVE_WR_READY  out  1  registered ready.
- SEND_MT_VALID  out  1  registered match-token valid.
- SEND_MT_DATA  out  MT_WIDTH  registered match token.
- SEND_MT_READY  in  1  downstream ready.
- ERR_FULL  out  1  sticky: operand dropped because the table was full.
- ERR_DUP  out  1  sticky: operand dropped because an operand for the same side was already waiting.
- OCCUPANCY  out  clog2(ENTRIES+1)  count of valid table entries.

## Operation

- Option codes:
  - 2'b00 ONE: emit {addr, color, data, 0} immediately.
  - 2'b01 LEFT: operand for the left side.
  - 2'b10 RIGHT: operand for the right side.
  - 2'b11 DISCARD: drop the result silently; no flag.
- Each table entry holds {valid, side, addr, color, data}.
- LEFT/RIGHT lookup is a fully associative compare on addr and color over valid entries, evaluated in the cycle after capture.
  - Opposite-side hit: emit a token with data_left and data_right placed by side, then invalidate the hit entry. On multiple hits, the lowest index wins.
  - Same-side hit with no opposite-side hit: drop the operand and set ERR_DUP.
  - No hit and a free entry exists: store in the lowest free index and emit nothing.
  - No hit and table full: drop the operand and set ERR_FULL.
- FSM states: S_RECEIVE, S_LOOKUP, S_SEND.
  - S_RECEIVE to S_LOOKUP on RECEIVE_WR_VALID && RECEIVE_WR_READY. The input is captured into current_wr.
  - S_LOOKUP to S_SEND if a token is produced (ONE, or an opposite-side hit).
  - S_LOOKUP to S_RECEIVE otherwise (stored, dropped, or DISCARD).
  - S_SEND to S_RECEIVE on SEND_MT_VALID && SEND_MT_READY.
- Table update, occupancy update, error flags and SEND_MT_DATA/VALID loads all happen on the S_LOOKUP edge.
- OCCUPANCY: +1 on store, -1 on match, unchanged otherwise. It never exceeds ENTRIES.
- ERR_* flags clear only on reset.

## Timing

- Reset (asynchronous, RST_N=0): all outputs 0, all entries invalid, STATE=S_RECEIVE. A reset in any state aborts the current operation immediately. No token is emitted for the captured result.
- RECEIVE_WR_READY:
  - Rises on the first edge after reset release, and on the first edge after entering S_RECEIVE.
  - Falls on the edge that completes a handshake.
  - Never high outside S_RECEIVE.
- Capture at edge N gives lookup/update at edge N+1. SEND_MT_VALID is high from after N+1 when a token is produced.
- SEND_MT_VALID and SEND_MT_DATA hold stable until SEND_MT_READY. VALID falls on the handshake edge M. READY rises again at M+1.
- Latency: accept to token valid is 1 cycle after the capture edge. Best-case throughput is one result per 3 cycles for non-emitting results and per 4 cycles for emitting results with SEND_MT_READY held high.
- SEND_MT_READY may be high before VALID. No combinational path exists from any input to any output.

## Test plan

- Reset: hold RST_N low mid-S_SEND, release -> all outputs 0, OCCUPANCY=0, READY high one cycle after release.
- Pair: LEFT {addr=0x0010, color=0x0003, data=5}, then RIGHT with the same addr/color and data=7 -> one token {0x0010, 0x0003, 5, 7}. OCCUPANCY goes 1 then 0. Reversed arrival order gives the same token.
- Color isolation: LEFT (0x10, c=1, 1), then RIGHT (0x10, c=2, 2) -> no token, OCCUPANCY=2. Then RIGHT (0x10, c=1, 9) -> token {0x10, 1, 1, 9}.
- ONE/DISCARD with backpressure: ONE data=0xDEADBEEF with SEND_MT_READY low for 5 cycles -> VALID/DATA stable and READY low throughout. The token is {addr, color, 0xDEADBEEF, 0}. DISCARD -> no token, no flag.
- Full: store 8 unmatched LEFTs, send a 9th distinct LEFT -> dropped, ERR_FULL=1, OCCUPANCY=8. A matching RIGHT for entry 0 -> token, OCCUPANCY=7, ERR_FULL stays 1.
- Duplicate: LEFT (0x20, 0, 1), then LEFT (0x20, 0, 2) -> ERR_DUP=1, OCCUPANCY=1. RIGHT (0x20, 0, 3) -> token {0x20, 0, 1, 3}.
